// File: rtl/anim_sequencer.sv
// Frame-aligned sprite animation sequencer: loop, one-shot and play/pause with a programmable step rate.
// Define ANIM_PINGPONG_EN to make mode 2'b10 bounce between the first and last frame instead of looping.
module anim_sequencer #(
    parameter int NUM_FRAMES = 4,
    parameter int FRAME_W    = 2,
    parameter int RATE_W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               play,
    input  logic [1:0]         mode,
    input  logic [RATE_W-1:0]  rate,
    input  logic               restart,
    output logic [FRAME_W-1:0] frame_num,
    output logic [6:0]         frame_counter,
    output logic               step,
    output logic               done
);

    typedef enum logic [1:0] {
        S_STOPPED = 2'd0,
        S_PLAYING = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    localparam logic [FRAME_W-1:0] LAST = FRAME_W'(NUM_FRAMES - 1);

    state_t              state, state_nx;
    logic [FRAME_W-1:0]  frame_nx;
    logic [RATE_W-1:0]   div_cnt, div_nx;
    logic                step_nx;
    logic                done_nx;
`ifdef ANIM_PINGPONG_EN
    logic                dir, dir_nx;   // 0 = counting up, 1 = counting down
`endif

    always_comb begin
        state_nx = state;
        frame_nx = frame_num;
        div_nx   = div_cnt;
        step_nx  = 1'b0;
        done_nx  = done;
`ifdef ANIM_PINGPONG_EN
        dir_nx   = dir;
`endif
        if (restart) begin
            // restart beats a coincident tick, so no advance can happen here
            frame_nx = '0;
            div_nx   = '0;
            done_nx  = 1'b0;
            state_nx = play ? S_PLAYING : S_STOPPED;
`ifdef ANIM_PINGPONG_EN
            dir_nx   = 1'b0;
`endif
        end else if (frame_tick) begin
            case (state)
                S_STOPPED: begin
                    if (play)
                        state_nx = S_PLAYING;
                end
                S_PLAYING: begin
                    if (!play) begin
                        state_nx = S_STOPPED;
                    end else if (div_cnt >= rate) begin
                        // >= so that lowering rate below the running count fires at once
                        div_nx = '0;
                        if (mode == 2'b01 && frame_num == LAST) begin
                            state_nx = S_DONE;
                            done_nx  = 1'b1;
`ifdef ANIM_PINGPONG_EN
                        end else if (mode == 2'b10) begin
                            step_nx = 1'b1;
                            if (frame_num == LAST || (dir && frame_num != '0)) begin
                                frame_nx = frame_num - 1'b1;
                                dir_nx   = (frame_nx != '0);
                            end else begin
                                frame_nx = frame_num + 1'b1;
                                dir_nx   = (frame_nx == LAST);
                            end
`endif
                        end else begin
                            step_nx  = 1'b1;
                            frame_nx = (frame_num == LAST) ? '0 : frame_num + 1'b1;
                        end
                    end else begin
                        div_nx = div_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_STOPPED;
            frame_num     <= '0;
            div_cnt       <= '0;
            step          <= 1'b0;
            done          <= 1'b0;
            frame_counter <= '0;
`ifdef ANIM_PINGPONG_EN
            dir           <= 1'b0;
`endif
        end else begin
            state     <= state_nx;
            frame_num <= frame_nx;
            div_cnt   <= div_nx;
            step      <= step_nx;
            done      <= done_nx;
`ifdef ANIM_PINGPONG_EN
            dir       <= dir_nx;
`endif
            if (frame_tick)
                frame_counter <= frame_counter + 7'd1;
        end
    end

endmodule

// File: tb/tb_anim_sequencer.sv
// Self-checking bench for anim_sequencer: directed corner cases, a vector table and a randomized run
// against a behavioural model.
module tb_anim_sequencer;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frame_tick = 1'b0;
    logic       play = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [3:0] rate = 4'd0;
    logic       restart = 1'b0;
    logic [1:0] frame_num;
    logic [6:0] frame_counter;
    logic       step;
    logic       done;

    int total = 0;
    int bad = 0;

    anim_sequencer #(.NUM_FRAMES(N), .FRAME_W(2), .RATE_W(4)) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .play(play), .mode(mode),
        .rate(rate), .restart(restart), .frame_num(frame_num), .frame_counter(frame_counter),
        .step(step), .done(done)
    );

    always #5 clk = ~clk;

    // Behavioural model: phase 0 stopped, 1 playing, 2 finished
    int m_fn, m_cnt, m_phase, m_fc;
    bit m_up, m_step, m_done;

    task automatic model_advance();
        int eff;
        eff = mode;
`ifndef ANIM_PINGPONG_EN
        if (eff == 2) eff = 0;
`endif
        if (eff == 3) eff = 0;
        if (eff == 1 && m_fn == N - 1) begin
            m_phase = 2;
            m_done = 1;
        end else if (eff == 2) begin
            if (m_up && m_fn == N - 1) m_up = 0;
            if (!m_up && m_fn == 0) m_up = 1;
            m_fn = m_up ? m_fn + 1 : m_fn - 1;
            if (m_fn == N - 1) m_up = 0;
            else if (m_fn == 0) m_up = 1;
            m_step = 1;
        end else begin
            m_fn = (m_fn + 1) % N;
            m_step = 1;
        end
    endtask

    task automatic model_update();
        if (reset) begin
            m_fn = 0; m_cnt = 0; m_phase = 0; m_fc = 0; m_up = 1; m_step = 0; m_done = 0;
        end else begin
            m_step = 0;
            if (frame_tick) m_fc = (m_fc + 1) % 128;
            if (restart) begin
                m_fn = 0; m_cnt = 0; m_up = 1; m_done = 0;
                m_phase = play ? 1 : 0;
            end else if (frame_tick) begin
                if (m_phase == 0) begin
                    if (play) m_phase = 1;
                end else if (m_phase == 1) begin
                    if (!play) m_phase = 0;
                    else if (m_cnt >= int'(rate)) begin
                        m_cnt = 0;
                        model_advance();
                    end else m_cnt = m_cnt + 1;
                end
            end
        end
    endtask

    task automatic clk_cycle();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1; frame_tick = 0; restart = 0;
        clk_cycle();
        reset = 0;
    endtask

    task automatic do_tick(input bit p, output bit s);
        frame_tick = 1; play = p;
        clk_cycle();
        s = step;
        frame_tick = 0;
        clk_cycle();
    endtask

    typedef struct {
        bit tk; bit pl; bit [1:0] md; bit [3:0] rt; bit rs;
        int fn; int st; int dn; int fc;
    } vec_t;
    vec_t vt[16];

    initial begin
        bit s;
        int steps;
        int exp_fn1[6];
        int exp_dn1[6];
        int exp_pp[8];

        // Reset state, then loop mode at rate 7 over 40 ticks
        mode = 2'b00; rate = 4'd7; play = 1;
        do_reset();
        chk("reset_fn", frame_num, 0);
        chk("reset_fc", frame_counter, 0);
        chk("reset_step", step, 0);
        chk("reset_done", done, 0);
        steps = 0;
        for (int i = 1; i <= 40; i++) begin
            do_tick(1, s);
            steps += s;
            case (i)
                8:  chk("loop_t8", frame_num, 0);
                9:  chk("loop_t9", frame_num, 1);
                17: chk("loop_t17", frame_num, 2);
                25: chk("loop_t25", frame_num, 3);
                33: chk("loop_t33", frame_num, 0);
                default: ;
            endcase
        end
        chk("loop_steps", steps, 4);
        chk("loop_fc", frame_counter, 40);

        // One-shot at rate 0, then restart
        exp_fn1 = '{0, 1, 2, 3, 3, 3};
        exp_dn1 = '{0, 0, 0, 0, 1, 1};
        do_reset();
        mode = 2'b01; rate = 4'd0;
        for (int i = 0; i < 6; i++) begin
            do_tick(1, s);
            chk("oneshot_fn", frame_num, exp_fn1[i]);
            chk("oneshot_done", done, exp_dn1[i]);
        end
        do_tick(1, s);
        chk("oneshot_hold", frame_num, 3);
        restart = 1; play = 1;
        clk_cycle();
        restart = 0;
        chk("restart_fn", frame_num, 0);
        chk("restart_done", done, 0);
        do_tick(1, s);
        chk("restart_playing", frame_num, 1);

        // Pause keeps div_cnt; resume tick does not count
        do_reset();
        mode = 2'b00; rate = 4'd3;
        do_tick(1, s); do_tick(1, s); do_tick(1, s);
        do_tick(0, s);
        do_tick(1, s);
        do_tick(1, s);
        chk("pause_no_adv", frame_num, 0);
        do_tick(1, s);
        chk("pause_adv", frame_num, 1);
        chk("pause_step", s, 1);

        // Restart coincident with an advancing tick
        do_reset();
        rate = 4'd0;
        do_tick(1, s); do_tick(1, s);
        frame_tick = 1; restart = 1; play = 1;
        clk_cycle();
        frame_tick = 0; restart = 0;
        chk("rt_tick_step", step, 0);
        chk("rt_tick_fn", frame_num, 0);
        chk("rt_tick_fc", frame_counter, 3);

        // Mode 10: bounce with the optional feature, plain loop without it
`ifdef ANIM_PINGPONG_EN
        exp_pp = '{1, 2, 3, 2, 1, 0, 1, 2};
`else
        exp_pp = '{1, 2, 3, 0, 1, 2, 3, 0};
`endif
        do_reset();
        mode = 2'b10; rate = 4'd0;
        do_tick(1, s);
        for (int i = 0; i < 8; i++) begin
            do_tick(1, s);
            chk("mode10_seq", frame_num, exp_pp[i]);
        end

        // Reset with a coincident tick mid-run
        do_reset();
        mode = 2'b00; rate = 4'd0;
        do_tick(1, s); do_tick(1, s); do_tick(1, s);
        chk("midrst_pre", frame_num, 2);
        reset = 1; frame_tick = 1; play = 1;
        clk_cycle();
        reset = 0; frame_tick = 0;
        chk("midrst_fn", frame_num, 0);
        chk("midrst_fc", frame_counter, 0);
        chk("midrst_step", step, 0);
        chk("midrst_done", done, 0);
        do_tick(1, s);
        chk("midrst_stopped", frame_num, 0);
        do_tick(1, s);
        chk("midrst_run", frame_num, 1);

        // Vector table, one clock per entry
        vt[0]  = '{1, 1, 2'd0, 4'd0, 0, 0, 0, 0, 1};
        vt[1]  = '{0, 1, 2'd0, 4'd0, 0, 0, 0, 0, 1};
        vt[2]  = '{1, 1, 2'd0, 4'd0, 0, 1, 1, 0, 2};
        vt[3]  = '{0, 1, 2'd0, 4'd0, 0, 1, 0, 0, 2};
        vt[4]  = '{1, 1, 2'd1, 4'd0, 0, 2, 1, 0, 3};
        vt[5]  = '{1, 1, 2'd1, 4'd0, 0, 3, 1, 0, 4};
        vt[6]  = '{1, 1, 2'd1, 4'd0, 0, 3, 0, 1, 5};
        vt[7]  = '{1, 1, 2'd1, 4'd0, 0, 3, 0, 1, 6};
        vt[8]  = '{0, 0, 2'd0, 4'd0, 1, 0, 0, 0, 6};
        vt[9]  = '{1, 0, 2'd0, 4'd0, 0, 0, 0, 0, 7};
        vt[10] = '{1, 1, 2'd0, 4'd0, 0, 0, 0, 0, 8};
        vt[11] = '{1, 1, 2'd0, 4'd1, 0, 0, 0, 0, 9};
        vt[12] = '{1, 1, 2'd0, 4'd1, 0, 1, 1, 0, 10};
        vt[13] = '{1, 1, 2'd0, 4'd2, 0, 1, 0, 0, 11};
        vt[14] = '{1, 1, 2'd0, 4'd0, 0, 2, 1, 0, 12};
        vt[15] = '{1, 1, 2'd0, 4'd0, 1, 0, 0, 0, 13};
        do_reset();
        for (int i = 0; i < 16; i++) begin
            frame_tick = vt[i].tk; play = vt[i].pl; mode = vt[i].md;
            rate = vt[i].rt; restart = vt[i].rs;
            clk_cycle();
            chk("vec_fn", frame_num, vt[i].fn);
            chk("vec_step", step, vt[i].st);
            chk("vec_done", done, vt[i].dn);
            chk("vec_fc", frame_counter, vt[i].fc);
        end
        frame_tick = 0; restart = 0;

        // Randomized run against the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            reset      = ($urandom_range(0, 199) == 0);
            frame_tick = ($urandom_range(0, 2) == 0);
            play       = ($urandom_range(0, 9) != 0);
            mode       = 2'($urandom_range(0, 3));
            rate       = 4'($urandom_range(0, 3));
            restart    = ($urandom_range(0, 59) == 0);
            clk_cycle();
            total++;
            if (int'(frame_num) != m_fn || int'(step) != int'(m_step) ||
                int'(done) != int'(m_done) || int'(frame_counter) != m_fc) begin
                bad++;
                $display("FAIL rand[%0d]: got fn=%0d step=%0d done=%0d fc=%0d expected fn=%0d step=%0d done=%0d fc=%0d",
                         i, frame_num, step, done, frame_counter, m_fn, m_step, m_done, m_fc);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
